// File: rtl/trig_event_wb_master_if.sv
// Wishbone initiator-side bundle between the trigger event master and the PCI bridge WBS_* port.
interface trig_event_wb_master_if;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_cab_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic        wbm_ack_i;
    logic        wbm_err_i;
    logic        wbm_rty_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
               wbm_cab_o, wbm_cti_o, wbm_bte_o,
        input  wbm_ack_i, wbm_err_i, wbm_rty_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
               wbm_cab_o, wbm_cti_o, wbm_bte_o,
        output wbm_ack_i, wbm_err_i, wbm_rty_i
    );
endinterface

// File: rtl/trig_event_wb_master.sv
// Queues trigger event words and writes them one by one into a host-memory ring via single Wishbone writes.
// Optional TRIG_EVT_WB_TIMEOUT_EN: a stuck write is abandoned after 1023 cycles and handled like err_i.
module trig_event_wb_master #(
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int RING_AW         = 10,
    parameter int RETRY_GAP       = 8
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   enable_i,
    input  logic [31:0]            ring_base_i,
    input  logic [RING_AW-1:0]     host_rd_ptr_i,
    input  logic                   evt_valid_i,
    input  logic [31:0]            evt_data_i,
    trig_event_wb_master_if.master wbm,
    output logic [RING_AW-1:0]     wr_ptr_o,
    output logic                   irq_o,
    output logic [15:0]            drop_cnt_o,
    output logic                   bus_err_o
);
    localparam int FA    = FIFO_DEPTH_LOG2;
    localparam int PW    = FA + 1;
    localparam int DEPTH = 2 ** FA;
    localparam int RC_W  = $clog2(RETRY_GAP + 1);

    typedef enum logic [1:0] {IDLE, REQ, RETRY} state_t;

    state_t              state_q, state_d;
    logic                cyc_q, cyc_d;
    logic [31:0]         adr_q, adr_d;
    logic [31:0]         dat_q, dat_d;
    logic [RING_AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic                irq_q, irq_d;
    logic [15:0]         drop_cnt_q, drop_cnt_d;
    logic                bus_err_q, bus_err_d;
    logic [RC_W-1:0]     retry_cnt_q, retry_cnt_d;
    logic [PW-1:0]       fifo_wr_q, fifo_wr_d;
    logic [PW-1:0]       fifo_rd_q, fifo_rd_d;
    logic [31:0]         fifo_mem [DEPTH];

    logic                fifo_empty, fifo_full, fifo_push, fifo_pop;
    logic                ring_full, req_timeout;
    logic [RING_AW-1:0]  wr_ptr_inc;

    assign fifo_empty = (fifo_wr_q == fifo_rd_q);
    assign fifo_full  = (fifo_wr_q[FA] != fifo_rd_q[FA]) && (fifo_wr_q[FA-1:0] == fifo_rd_q[FA-1:0]);
    assign wr_ptr_inc = wr_ptr_q + RING_AW'(1);
    assign ring_full  = (wr_ptr_inc == host_rd_ptr_i);

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign fifo_push  = evt_valid_i && enable_i && (!fifo_full || fifo_pop);

`ifdef TRIG_EVT_WB_TIMEOUT_EN
    logic [9:0] to_cnt_q, to_cnt_d;

    always_comb begin
        to_cnt_d = '0;
        if (state_q == REQ) to_cnt_d = to_cnt_q + 10'd1;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) to_cnt_q <= '0;
        else          to_cnt_q <= to_cnt_d;
    end

    assign req_timeout = (state_q == REQ) && (to_cnt_q == 10'd1022);
`else
    assign req_timeout = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        wr_ptr_d    = wr_ptr_q;
        bus_err_d   = bus_err_q;
        retry_cnt_d = retry_cnt_q;
        fifo_pop    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable_i && !fifo_empty && !ring_full) begin
                    state_d = REQ;
                    cyc_d   = 1'b1;
                    adr_d   = (ring_base_i + {{(30-RING_AW){1'b0}}, wr_ptr_q, 2'b00}) & ~32'h3;
                    dat_d   = fifo_mem[fifo_rd_q[FA-1:0]];
                end
            end
            REQ: begin
                // ack > err > rty; a timeout behaves exactly like err.
                if (wbm.wbm_ack_i) begin
                    state_d  = IDLE;
                    cyc_d    = 1'b0;
                    fifo_pop = 1'b1;
                    wr_ptr_d = wr_ptr_inc;
                end else if (wbm.wbm_err_i || req_timeout) begin
                    state_d   = IDLE;
                    cyc_d     = 1'b0;
                    fifo_pop  = 1'b1;
                    bus_err_d = 1'b1;
                end else if (wbm.wbm_rty_i) begin
                    state_d     = (RETRY_GAP < 2) ? IDLE : RETRY;
                    cyc_d       = 1'b0;
                    retry_cnt_d = '0;
                end
            end
            RETRY: begin
                // The IDLE cycle that follows is the last of the RETRY_GAP idle cycles.
                if (int'(retry_cnt_q) >= RETRY_GAP - 2) state_d = IDLE;
                else                                    retry_cnt_d = retry_cnt_q + RC_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fifo_wr_d  = fifo_push ? fifo_wr_q + PW'(1) : fifo_wr_q;
        fifo_rd_d  = fifo_pop  ? fifo_rd_q + PW'(1) : fifo_rd_q;
        irq_d      = (wr_ptr_q != host_rd_ptr_i);
        drop_cnt_d = drop_cnt_q;
        if (evt_valid_i && !fifo_push && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            cyc_q       <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            wr_ptr_q    <= '0;
            irq_q       <= 1'b0;
            drop_cnt_q  <= '0;
            bus_err_q   <= 1'b0;
            retry_cnt_q <= '0;
            fifo_wr_q   <= '0;
            fifo_rd_q   <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            wr_ptr_q    <= wr_ptr_d;
            irq_q       <= irq_d;
            drop_cnt_q  <= drop_cnt_d;
            bus_err_q   <= bus_err_d;
            retry_cnt_q <= retry_cnt_d;
            fifo_wr_q   <= fifo_wr_d;
            fifo_rd_q   <= fifo_rd_d;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (fifo_push) fifo_mem[fifo_wr_q[FA-1:0]] <= evt_data_i;
    end

    assign wbm.wbm_cyc_o = cyc_q;
    assign wbm.wbm_stb_o = cyc_q;
    assign wbm.wbm_we_o  = cyc_q;
    assign wbm.wbm_sel_o = {4{cyc_q}};
    assign wbm.wbm_adr_o = adr_q;
    assign wbm.wbm_dat_o = dat_q;
    assign wbm.wbm_cab_o = 1'b0;
    assign wbm.wbm_cti_o = 3'b000;
    assign wbm.wbm_bte_o = 2'b00;

    assign wr_ptr_o   = wr_ptr_q;
    assign irq_o      = irq_q;
    assign drop_cnt_o = drop_cnt_q;
    assign bus_err_o  = bus_err_q;
endmodule
